// File: rtl/leg_reg_sequencer_if.sv
// Bus between the LEG instruction source / ALU and the register-bank
// sequencer. The sequencer uses the slave modport; the instruction source,
// ALU and register bank together form the master side.
interface leg_reg_sequencer_if #(
  parameter int NUM_REGS   = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  instr_valid;
  logic [31:0]           instr;
  logic                  instr_ready;
  logic [NUM_REGS-1:0]   Read_A;
  logic [NUM_REGS-1:0]   Read_B;
  logic [NUM_REGS-1:0]   Write;
  logic [DATA_WIDTH-1:0] Write_Value;
  logic [7:0]            alu_op;
  logic                  imm_a_en;
  logic                  imm_b_en;
  logic [DATA_WIDTH-1:0] imm_a;
  logic [DATA_WIDTH-1:0] imm_b;
  logic                  op_valid;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  done;

  modport slave (
    input  instr_valid, instr, result_valid, result,
    output instr_ready, Read_A, Read_B, Write, Write_Value, alu_op,
           imm_a_en, imm_b_en, imm_a, imm_b, op_valid, done
  );

  modport master (
    output instr_valid, instr, result_valid, result,
    input  instr_ready, Read_A, Read_B, Write, Write_Value, alu_op,
           imm_a_en, imm_b_en, imm_a, imm_b, op_valid, done
  );
endinterface

// File: rtl/leg_reg_sequencer.sv
// LEG register-bank sequencer: accepts one instruction, strobes the operand
// registers until the ALU answers, then writes the result back on a single
// clock edge. Conditional instructions retire without write-back.
module leg_reg_sequencer #(
  parameter int NUM_REGS   = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  leg_reg_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [7:0]            alu_op_q;
  logic                  imm_a_en_q, imm_b_en_q;
  logic [DATA_WIDTH-1:0] imm_a_q, imm_b_q;
  logic [2:0]            sel_a_q, sel_b_q, dest_q;
  logic                  cond_q;
  logic [DATA_WIDTH-1:0] wval_q;
  logic                  done_q;

  logic                  accept;
  logic                  retire;
  logic [NUM_REGS-1:0]   read_a, read_b, write;

  // Upper dest bits never select a register.
  logic                  unused_dest_hi;
  assign unused_dest_hi = ^bus.instr[31:27];

  assign accept = (state_q == S_IDLE) && bus.instr_valid;
  assign retire = (state_q == S_READ) && bus.result_valid;

  // Next-state logic; result_valid only matters while in READ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.instr_valid) state_d = S_READ;
      S_READ:  if (bus.result_valid) state_d = cond_q ? S_IDLE : S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wins over everything, aborting any in-flight op.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Instruction field latches, loaded only when an instruction is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_op_q   <= '0;
      imm_a_en_q <= 1'b0;
      imm_b_en_q <= 1'b0;
      imm_a_q    <= '0;
      imm_b_q    <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      dest_q     <= '0;
      cond_q     <= 1'b0;
    end else if (accept) begin
      alu_op_q   <= bus.instr[7:0];
      imm_a_en_q <= bus.instr[7];
      imm_b_en_q <= bus.instr[6];
      cond_q     <= bus.instr[5];
      imm_a_q    <= DATA_WIDTH'(bus.instr[15:8]);
      imm_b_q    <= DATA_WIDTH'(bus.instr[23:16]);
      sel_a_q    <= bus.instr[10:8];
      sel_b_q    <= bus.instr[18:16];
      dest_q     <= bus.instr[26:24];
    end
  end

  // Write-back data is captured from the ALU and held until the next write.
  always_ff @(posedge clk) begin
    if (!rst)                   wval_q <= '0;
    else if (retire && !cond_q) wval_q <= bus.result;
  end

  // done marks the cycle after the ALU answers: the WRITE cycle for normal
  // instructions, the first IDLE cycle for conditional ones.
  always_ff @(posedge clk) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= retire;
  end

  // One-hot strobes decoded from registered state; indices >= NUM_REGS
  // have no strobe bit and therefore select nothing.
  always_comb begin
    read_a = '0;
    read_b = '0;
    write  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      read_a[i] = (state_q == S_READ)  && !imm_a_en_q && (sel_a_q == 3'(i));
      read_b[i] = (state_q == S_READ)  && !imm_b_en_q && (sel_b_q == 3'(i));
      write[i]  = (state_q == S_WRITE) && (dest_q == 3'(i));
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.op_valid    = (state_q == S_READ);
  assign bus.Read_A      = read_a;
  assign bus.Read_B      = read_b;
  assign bus.Write       = write;
  assign bus.Write_Value = wval_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.imm_a_en    = imm_a_en_q;
  assign bus.imm_b_en    = imm_b_en_q;
  assign bus.imm_a       = imm_a_q;
  assign bus.imm_b       = imm_b_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_leg_reg_sequencer.sv
// Directed bench for leg_reg_sequencer: table of instructions with
// hand-computed strobes, plus reset and idle corner-case sequences.
module tb_leg_reg_sequencer;

  logic clk = 1'b0;
  logic rst;

  leg_reg_sequencer_if #(.NUM_REGS(6), .DATA_WIDTH(8)) bus ();

  leg_reg_sequencer #(.NUM_REGS(6), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          lat;   // READ cycles before result_valid is raised
    logic [7:0]  res;
    logic [5:0]  ra;
    logic [5:0]  rb;
    logic [5:0]  wr;
    logic        cond;
  } vec_t;

  vec_t       vt [7];
  int         ncmp = 0;
  int         nerr = 0;
  logic [7:0] last_wval;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".Read_A"},      32'(bus.Read_A), 0);
    chk({tag, ".Read_B"},      32'(bus.Read_B), 0);
    chk({tag, ".Write"},       32'(bus.Write), 0);
    chk({tag, ".Write_Value"}, 32'(bus.Write_Value), 0);
    chk({tag, ".alu_op"},      32'(bus.alu_op), 0);
    chk({tag, ".imm"},         32'({bus.imm_a, bus.imm_b}), 0);
    chk({tag, ".imm_en"},      32'({bus.imm_a_en, bus.imm_b_en}), 0);
    chk({tag, ".op_valid"},    32'(bus.op_valid), 0);
    chk({tag, ".done"},        32'(bus.done), 0);
  endtask

  initial begin
    //                instr         lat res    Read_A     Read_B     Write      cond
    vt[0] = '{32'h03020100, 0, 8'h5A, 6'b000010, 6'b000100, 6'b001000, 1'b0}; // ADD r1,r2 -> r3
    vt[1] = '{32'h000907C0, 1, 8'h33, 6'b000000, 6'b000000, 6'b000001, 1'b0}; // both immediate
    vt[2] = '{32'h02050420, 4, 8'h99, 6'b010000, 6'b100000, 6'b000000, 1'b1}; // conditional
    vt[3] = '{32'h06010000, 0, 8'h77, 6'b000001, 6'b000010, 6'b000000, 1'b0}; // dest out of range
    vt[4] = '{32'hFD09F901, 2, 8'hA5, 6'b000010, 6'b000010, 6'b100000, 1'b0}; // same reg, upper bits
    vt[5] = '{32'h04030740, 0, 8'h11, 6'b000000, 6'b000000, 6'b010000, 1'b0}; // arg1 out of range, imm_b
    vt[6] = '{32'h01030280, 0, 8'hEE, 6'b000000, 6'b001000, 6'b000010, 1'b0}; // imm_a only

    // Reset held with an instruction offered: nothing may be accepted.
    rst = 1'b0; bus.instr_valid = 1'b1; bus.instr = 32'h03020100;
    bus.result_valid = 1'b0; bus.result = '0;
    step; step;
    chk_all_zero("reset");
    rst = 1'b1; bus.instr_valid = 1'b0;
    chk("reset.instr_ready", 32'(bus.instr_ready), 1);
    step;
    chk("post_reset.instr_ready", 32'(bus.instr_ready), 1);
    chk("post_reset.op_valid", 32'(bus.op_valid), 0);
    last_wval = 8'h00;

    // Table-driven instructions.
    for (int v = 0; v < 7; v++) begin
      string t;
      t = $sformatf("v%0d", v);
      chk({t, ".ready"}, 32'(bus.instr_ready), 1);
      bus.instr_valid = 1'b1; bus.instr = vt[v].instr;
      step;
      bus.instr_valid = 1'b0;
      for (int k = 0; k <= vt[v].lat; k++) begin
        chk({t, ".Read_A"},   32'(bus.Read_A), 32'(vt[v].ra));
        chk({t, ".Read_B"},   32'(bus.Read_B), 32'(vt[v].rb));
        chk({t, ".op_valid"}, 32'(bus.op_valid), 1);
        chk({t, ".rd_ready"}, 32'(bus.instr_ready), 0);
        chk({t, ".rd_Write"}, 32'(bus.Write), 0);
        chk({t, ".rd_done"},  32'(bus.done), 0);
        if (k == 0) begin
          chk({t, ".alu_op"},   32'(bus.alu_op), 32'(vt[v].instr[7:0]));
          chk({t, ".imm_a"},    32'(bus.imm_a), 32'(vt[v].instr[15:8]));
          chk({t, ".imm_b"},    32'(bus.imm_b), 32'(vt[v].instr[23:16]));
          chk({t, ".imm_a_en"}, 32'(bus.imm_a_en), 32'(vt[v].instr[7]));
          chk({t, ".imm_b_en"}, 32'(bus.imm_b_en), 32'(vt[v].instr[6]));
        end
        if (k == vt[v].lat) begin
          bus.result_valid = 1'b1; bus.result = vt[v].res;
        end
        step;
      end
      bus.result_valid = 1'b0;
      if (vt[v].cond) begin
        chk({t, ".c_done"},  32'(bus.done), 1);
        chk({t, ".c_Write"}, 32'(bus.Write), 0);
        chk({t, ".c_ready"}, 32'(bus.instr_ready), 1);
        chk({t, ".c_wval"},  32'(bus.Write_Value), 32'(last_wval));
        chk({t, ".c_opv"},   32'(bus.op_valid), 0);
      end else begin
        last_wval = vt[v].res;
        chk({t, ".Write"},       32'(bus.Write), 32'(vt[v].wr));
        chk({t, ".Write_Value"}, 32'(bus.Write_Value), 32'(vt[v].res));
        chk({t, ".wr_done"},     32'(bus.done), 1);
        chk({t, ".wr_Read"},     32'({bus.Read_A, bus.Read_B}), 0);
        chk({t, ".wr_opv"},      32'(bus.op_valid), 0);
        chk({t, ".wr_ready"},    32'(bus.instr_ready), 0);
      end
      step;
      chk({t, ".end_done"},  32'(bus.done), 0);
      chk({t, ".end_Write"}, 32'(bus.Write), 0);
      chk({t, ".end_ready"}, 32'(bus.instr_ready), 1);
      chk({t, ".end_wval"},  32'(bus.Write_Value), 32'(last_wval));
    end

    // result_valid while IDLE is ignored.
    bus.result_valid = 1'b1; bus.result = 8'h42;
    step;
    bus.result_valid = 1'b0;
    chk("idle_rv.ready", 32'(bus.instr_ready), 1);
    chk("idle_rv.done",  32'(bus.done), 0);
    chk("idle_rv.Write", 32'(bus.Write), 0);
    chk("idle_rv.wval",  32'(bus.Write_Value), 32'(last_wval));
    step;
    chk("idle_rv.done2", 32'(bus.done), 0);

    // Reset during READ with result_valid: no write-back, no done.
    bus.instr_valid = 1'b1; bus.instr = 32'h03020100;
    step;
    bus.instr_valid = 1'b0;
    chk("mid.op_valid", 32'(bus.op_valid), 1);
    bus.result_valid = 1'b1; bus.result = 8'hC3; rst = 1'b0;
    step;
    chk_all_zero("mid_rst");
    chk("mid_rst.ready", 32'(bus.instr_ready), 1);
    rst = 1'b1; bus.result_valid = 1'b0;
    step;
    chk("mid_after.Write", 32'(bus.Write), 0);
    chk("mid_after.done",  32'(bus.done), 0);
    chk("mid_after.ready", 32'(bus.instr_ready), 1);
    chk("mid_after.wval",  32'(bus.Write_Value), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/leg_reg_sequencer.md
Name: leg_reg_sequencer

Overview:
- Control stage directly upstream of the 8-bit general-purpose register bank in the LEG CPU.
- Accepts one 32-bit LEG instruction at a time and drives the per-register read strobes (A and B ports) and write strobes.
- Exposes decoded operands and the opcode to the ALU, waits for the ALU result, then performs a one-cycle write-back into the destination register.
- Replaces ad-hoc combinational decode so that register writes occur on a single, well-defined clock edge.

Parameters:
- NUM_REGS, 6: number of general registers, indices 0..NUM_REGS-1. Legal range 1..8.
- DATA_WIDTH, 8: register and operand width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset: sampled on rising clk; 0 = reset.
- instr_valid  input  1  instruction present on instr.
- instr  input  32  [7:0] opcode, [15:8] arg1, [23:16] arg2, [31:24] dest.
- instr_ready  output  1  sequencer can accept an instruction.
- Read_A  output  NUM_REGS  one-hot read strobe, A port.
- Read_B  output  NUM_REGS  one-hot read strobe, B port.
- Write  output  NUM_REGS  one-hot write strobe.
- Write_Value  output  DATA_WIDTH  write-back data.
- alu_op  output  8  latched opcode.
- imm_a_en, imm_b_en  output  1 each  operand is immediate; ALU takes imm_a/imm_b instead of the register bus.
- imm_a, imm_b  output  DATA_WIDTH  latched arg1 and arg2.
- op_valid  output  1  operands/alu_op are valid; ALU may compute.
- result_valid  input  1  ALU result present.
- result  input  DATA_WIDTH  ALU result.
- done  output  1  one-cycle pulse on instruction retirement.

Behaviour:
- States: IDLE, READ, WRITE. Registered state; all outputs are registered or decoded from registered state only.
- Reset (rst=0 at a clk edge): state=IDLE. Outputs: Read_A=Read_B=Write=0, Write_Value=0, alu_op=0, imm_*=0, imm_*_en=0, op_valid=0, done=0. Reset aborts any in-flight instruction, and no Write strobe follows.
- IDLE:
  - instr_ready=1; all strobes 0.
  - On instr_valid=1: latch instr fields and go to READ.
  - Latched values: alu_op=opcode; imm_a_en=opcode[7]; imm_b_en=opcode[6]; imm_a=arg1; imm_b=arg2; dest index=dest[2:0]; cond flag=opcode[5].
- READ:
  - instr_ready=0; op_valid=1.
  - Read_A bit arg1[2:0] is set when imm_a_en=0 and arg1[2:0]<NUM_REGS; otherwise Read_A=0. Read_B follows the same rule using arg2 and imm_b_en.
  - Strobes are held stable until result_valid=1.
  - When result_valid=1:
    - If cond flag=1: go to IDLE and pulse done. No write-back occurs.
    - Otherwise: latch result into Write_Value and go to WRITE.
  - result_valid may arrive in the first READ cycle, giving minimum latency. There is no upper bound on wait time.
- WRITE (exactly one cycle):
  - Read_A=Read_B=0; op_valid=0.
  - Write bit dest[2:0] is set if dest[2:0]<NUM_REGS; otherwise Write=0.
  - done=1; next state IDLE.
  - Write_Value holds its value until the next write-back or reset.
- Upper dest bits [7:3] and upper arg bits are ignored for strobe selection.
- An instruction arriving while instr_ready=0 is not accepted; the source must hold it.
- Minimum throughput: non-conditional instruction = 3 cycles (IDLE, READ, WRITE); conditional instruction = 2 cycles.
- result_valid outside READ is ignored.
- Read_A and Read_B may select the same register. This is legal and both bits are set.
- Read and write of the same register in one instruction: the read occurs in READ, the write in WRITE. There is no overlap and no bypass is required.

Test Plan:
- Reset: hold rst=0 for 2 cycles with instr_valid=1 -> all outputs 0, state stays IDLE; after rst=1, instr_ready=1.
- ADD-style instr=0x03_02_01_00 (opcode 0x00, arg1=1, arg2=2, dest=3), result_valid=1 with result=0x5A in first READ cycle -> READ: Read_A=000010, Read_B=000100; next cycle Write=001000, Write_Value=0x5A, done=1; then instr_ready=1.
- Immediates: opcode 0xC0, arg1=0x07, arg2=0x09, dest=0 -> Read_A=Read_B=0, imm_a=0x07, imm_b=0x09, imm_a_en=imm_b_en=1; Write=000001 on write-back.
- Conditional: opcode 0x20, result_valid delayed 4 cycles -> Read strobes held for 4 cycles, then done pulse, Write never asserted.
- Out-of-range: dest=6 with NUM_REGS=6 -> WRITE cycle occurs, done=1, Write=0.
- Reset mid-op: rst=0 during READ with result_valid=1 -> next cycle IDLE, Write=0, done=0.
